dscan_rx: RTL and testbench
===========================

# dscan_rx

Receive side of the 4-digit multiplexed 7-segment display bus. Samples the anode-select lines (SA) and segment lines (L) and filters out glitches and blanking slots. Reassembles one full scan frame into four stable digit registers, with optional BCD decode. Used for loop-back self-test of the display path and for reading a multiplexed display back into logic.

## Interface
Parameters:
- STABLE_CYCLES, 2: consecutive identical samples (SA, L) required before a digit is captured; legal range 1–15.
- TIMEOUT, 1024: cycles without a completed frame before VALID drops; ≥ 2.

Ports:
- CLK  in  1  system clock; single clock domain.
- RST  in  1  reset, asynchronous, active-high.
- SA  in  4  anode select, one-hot active-high. SA[0] carries digit 4, SA[1] digit 3, SA[2] digit 2, SA[3] digit 1. 4'b0000 is a blanking slot.
- L  in  8  segment pattern, active-low, {dp,g,f,e,d,c,b,a}.
- D1..D4  out  8 each  last complete frame's raw segment pattern per digit.
- B1..B4  out  4 each  BCD decode of D1..D4. 4'hF means not a digit 0–9.
- VALID  out  1  high while D/B hold a frame completed within TIMEOUT cycles.
- FRAME  out  1  one-cycle pulse when D/B update.
- ERR  out  1  one-cycle pulse on a protocol error.

## Operation
- Input stage: SA and L are registered once (sa_q, l_q).
- Stability filter:
  - stab_cnt resets to 1 whenever {sa_q, l_q} differs from the previous cycle; otherwise it increments, saturating at 15.
  - A capture fires once, on the cycle stab_cnt reaches STABLE_CYCLES, if sa_q is one-hot.
  - No further capture fires until {sa_q, l_q} changes.
- Blanking (sa_q == 0): ignored; holds state, no error.
- Multi-hot sa_q that is stable for STABLE_CYCLES: ERR pulse, state goes to SYNC.
- FSM states:
  - SYNC: wait for a capture on SA[0], then store digit 4 and go to COLLECT with expected index 1.
  - COLLECT: a capture on the expected index stores that digit and increments the index.
  - Capture on SA[3] with index 3: copy all four shadow digits to D1..D4 and B1..B4, pulse FRAME, set VALID, clear the timeout counter, go to SYNC.
  - Out-of-order capture: ERR pulse. If the capture was on SA[0], restart collection with digit 4 stored; otherwise go to SYNC.
- Shadow registers are separate from D1..D4, so a partial frame never changes the outputs.
- Timeout counter: increments every cycle and saturates. On reaching TIMEOUT-1 it clears VALID. D/B keep their last values.
- Decode table, L[6:0] → value: 7'h40→0, 7'h79→1, 7'h24→2, 7'h30→3, 7'h19→4, 7'h12→5, 7'h02→6, 7'h78→7, 7'h00→8, 7'h10→9, anything else → 4'hF. L[7] (dp) is ignored.

## Timing
- Reset values: D1..D4 = 8'hFF, B1..B4 = 4'hF, VALID = 0, FRAME = 0, ERR = 0, FSM = SYNC, stab_cnt = 0, timeout counter = 0.
- Latency: pins stable from before edge n → shadow capture at edge n+STABLE_CYCLES. For the SA[3] digit, D/B/FRAME/VALID update at that same edge.
- FRAME and ERR never assert in the same cycle; a completing frame takes priority.
- If a frame completes on the same edge the timeout expires, VALID stays 1.
- RST asserted mid-frame clears all state immediately; the next frame must start from SA[0].
- Minimum accepted frame: 4 × STABLE_CYCLES + 1 cycles (one register stage of delay).

## Configuration
- DSCAN_BCD_EN defined: the decode sub-module is instantiated and B1..B4 follow the decode table.
- DSCAN_BCD_EN undefined: B1..B4 are tied to 4'hF and no decode logic is built. D/VALID/FRAME/ERR behaviour is identical in both builds.

## Structure
- Shared package dscan_pkg holds:
  - 7-bit segment pattern constants SEG_0..SEG_9 and SEG_BLANK (7'h7F).
  - FSM state encoding (SYNC, COLLECT).
  - Digit index constants.
- One sub-module, seg7_dec: purely combinational, 8-bit pattern → 4-bit BCD. Instantiated four times.

## Test plan
- Reset: RST pulsed mid-stream → all outputs at reset values; first FRAME appears only after a full SA[0]..SA[3] sequence.
- Nominal: scan 0001/L=C0, 0010/F9, 0100/A4, 1000/B0, each held 4 cycles with blanking between → D1..D4 = B0,A4,F9,C0; B1..B4 = 3,2,1,0; FRAME one pulse; VALID = 1.
- Glitch: one-cycle L=8'h00 spike inside a slot with STABLE_CYCLES=2 → no capture of 8'h00; frame decodes unchanged.
- Order error: SA[0], then SA[2] → ERR pulse, no FRAME, D unchanged; recovery on the next clean frame.
- Multi-hot: SA=0011 stable for 3 cycles → ERR pulse, FSM in SYNC.
- Timeout and macro: TIMEOUT=64, stop scanning → VALID falls exactly 64 cycles after FRAME. Rebuild without DSCAN_BCD_EN → B1..B4 = F, D values identical.

Source files
------------

// File: rtl/dscan_pkg.sv
// Shared constants for the multiplexed 7-segment display receiver:
// segment patterns (active-low, {g..a}), FSM states and digit slot indices.
package dscan_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic {
    SYNC,
    COLLECT
  } state_t;

  // SA bit position carrying each displayed digit
  localparam logic [1:0] IDX_D4 = 2'd0;
  localparam logic [1:0] IDX_D3 = 2'd1;
  localparam logic [1:0] IDX_D2 = 2'd2;
  localparam logic [1:0] IDX_D1 = 2'd3;

endpackage

// File: rtl/dscan_rx_seg7_dec.sv
// Combinational 7-segment (active-low) to BCD decoder; 4'hF for non-digits.
// The decimal point bit is masked off before matching.
module seg7_dec
  import dscan_pkg::*;
(
  input  logic [7:0] i_seg,
  output logic [3:0] o_bcd
);

  logic [7:0] w_seg;

  always_comb begin
    w_seg = i_seg & 8'h7F;
    o_bcd = 4'hF;
    case (w_seg)
      {1'b0, SEG_0}: o_bcd = 4'd0;
      {1'b0, SEG_1}: o_bcd = 4'd1;
      {1'b0, SEG_2}: o_bcd = 4'd2;
      {1'b0, SEG_3}: o_bcd = 4'd3;
      {1'b0, SEG_4}: o_bcd = 4'd4;
      {1'b0, SEG_5}: o_bcd = 4'd5;
      {1'b0, SEG_6}: o_bcd = 4'd6;
      {1'b0, SEG_7}: o_bcd = 4'd7;
      {1'b0, SEG_8}: o_bcd = 4'd8;
      {1'b0, SEG_9}: o_bcd = 4'd9;
      default:       o_bcd = 4'hF;
    endcase
  end

endmodule

// File: rtl/dscan_rx.sv
// Receiver for a 4-digit multiplexed 7-segment bus: filters SA/L, reassembles
// a scan frame into D1..D4. Define DSCAN_BCD_EN to build the B1..B4 decoders.
module dscan_rx
  import dscan_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 2,
  parameter int unsigned TIMEOUT       = 1024
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] SA,
  input  logic [7:0] L,
  output logic [7:0] D1,
  output logic [7:0] D2,
  output logic [7:0] D3,
  output logic [7:0] D4,
  output logic [3:0] B1,
  output logic [3:0] B2,
  output logic [3:0] B3,
  output logic [3:0] B4,
  output logic       VALID,
  output logic       FRAME,
  output logic       ERR
);

  localparam int unsigned   TW     = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMAX   = TW'(TIMEOUT - 1);
  localparam logic [3:0]    STABLE = 4'(STABLE_CYCLES);

  logic [3:0]    r_sa_q;
  logic [7:0]    r_l_q;
  logic [11:0]   r_prev;
  logic [3:0]    r_stab_cnt;
  state_t        r_state;
  logic [1:0]    r_idx;
  logic [7:0]    r_sh4, r_sh3, r_sh2;
  logic [TW-1:0] r_tcnt;

  logic       w_same, w_fire, w_onehot, w_multi;
  logic [3:0] w_next_cnt;
  logic [1:0] w_pos;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sa_q     <= '0;
      r_l_q      <= '0;
      r_prev     <= '0;
      r_stab_cnt <= '0;
    end else begin
      r_sa_q     <= SA;
      r_l_q      <= L;
      r_prev     <= {r_sa_q, r_l_q};
      r_stab_cnt <= w_next_cnt;
    end
  end

  // Capture fires only on the transition into STABLE, so a saturated run never refires.
  always_comb begin
    w_same     = ({r_sa_q, r_l_q} == r_prev);
    w_next_cnt = !w_same ? 4'd1 : ((r_stab_cnt == 4'd15) ? 4'd15 : r_stab_cnt + 4'd1);
    w_fire     = (w_next_cnt == STABLE) && (!w_same || (r_stab_cnt != STABLE));
    w_onehot   = $onehot(r_sa_q);
    w_multi    = (r_sa_q != '0) && !w_onehot;
    w_pos      = IDX_D4;
    case (r_sa_q)
      4'b0010: w_pos = IDX_D3;
      4'b0100: w_pos = IDX_D2;
      4'b1000: w_pos = IDX_D1;
      default: w_pos = IDX_D4;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= SYNC;
      r_idx   <= IDX_D3;
      r_sh4   <= '1;
      r_sh3   <= '1;
      r_sh2   <= '1;
      r_tcnt  <= '0;
      D1      <= '1;
      D2      <= '1;
      D3      <= '1;
      D4      <= '1;
      VALID   <= 1'b0;
      FRAME   <= 1'b0;
      ERR     <= 1'b0;
    end else begin
      FRAME <= 1'b0;
      ERR   <= 1'b0;
      if (r_tcnt == TMAX) VALID <= 1'b0;
      else                r_tcnt <= r_tcnt + 1'b1;

      if (w_fire && w_multi) begin
        ERR     <= 1'b1;
        r_state <= SYNC;
      end else if (w_fire && w_onehot) begin
        case (r_state)
          SYNC: begin
            if (w_pos == IDX_D4) begin
              r_sh4   <= r_l_q;
              r_idx   <= IDX_D3;
              r_state <= COLLECT;
            end
          end
          COLLECT: begin
            if (w_pos == r_idx) begin
              if (r_idx == IDX_D1) begin
                // frame completion overrides the timeout clear above
                D1      <= r_l_q;
                D2      <= r_sh2;
                D3      <= r_sh3;
                D4      <= r_sh4;
                FRAME   <= 1'b1;
                VALID   <= 1'b1;
                r_tcnt  <= '0;
                r_state <= SYNC;
              end else begin
                if (r_idx == IDX_D3) r_sh3 <= r_l_q;
                else                 r_sh2 <= r_l_q;
                r_idx <= r_idx + 2'd1;
              end
            end else begin
              ERR <= 1'b1;
              if (w_pos == IDX_D4) begin
                r_sh4 <= r_l_q;
                r_idx <= IDX_D3;
              end else begin
                r_state <= SYNC;
              end
            end
          end
          default: r_state <= SYNC;
        endcase
      end
    end
  end

`ifdef DSCAN_BCD_EN
  seg7_dec u_dec1 (.i_seg(D1), .o_bcd(B1));
  seg7_dec u_dec2 (.i_seg(D2), .o_bcd(B2));
  seg7_dec u_dec3 (.i_seg(D3), .o_bcd(B3));
  seg7_dec u_dec4 (.i_seg(D4), .o_bcd(B4));
`else
  assign B1 = 4'hF;
  assign B2 = 4'hF;
  assign B3 = 4'hF;
  assign B4 = 4'hF;
`endif

endmodule

// File: tb/tb_dscan_rx.sv
// Self-checking bench for dscan_rx: frame table, directed corner sequences and
// randomized scan traffic against a queue-based protocol model.
module tb_dscan_rx;

  localparam int unsigned S  = 2;
  localparam int unsigned TO = 64;
`ifdef DSCAN_BCD_EN
  localparam bit BCD_EN = 1'b1;
`else
  localparam bit BCD_EN = 1'b0;
`endif
  localparam logic [6:0] SEG_TBL [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                          7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  localparam logic [50:0] RESET_OUTS = {32'hFFFF_FFFF, 16'hFFFF, 3'b000};

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] SA;
  logic [7:0] L;
  logic [7:0] D1, D2, D3, D4;
  logic [3:0] B1, B2, B3, B4;
  logic       VALID, FRAME, ERR;

  dscan_rx #(.STABLE_CYCLES(S), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .SA(SA), .L(L),
    .D1(D1), .D2(D2), .D3(D3), .D4(D4),
    .B1(B1), .B2(B2), .B3(B3), .B4(B4),
    .VALID(VALID), .FRAME(FRAME), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int unsigned n_chk = 0, n_pass = 0, cyc = 0;
  int unsigned dut_frames = 0, dut_errs = 0;

  // Reference model: pin-run tracking plus an ordered list of collected digits.
  logic [11:0] m_prev;
  int unsigned m_run, m_age, last_frame_cyc;
  logic [7:0]  got[$];
  logic [7:0]  m_d[4];
  logic        m_valid, m_frame, m_err;

  typedef struct {
    logic [31:0] pins;   // bytes shown on SA[0], SA[1], SA[2], SA[3]
    logic [31:0] exp_d;  // {D1,D2,D3,D4}
    logic [15:0] exp_b;  // {B1,B2,B3,B4} with decoding enabled
  } frame_vec_t;
  frame_vec_t vecs[5];

  function automatic logic [3:0] dec(input logic [7:0] s);
    logic [3:0] code = 4'hF;
    for (int i = 0; i < 10; i++)
      if (s[6:0] == SEG_TBL[i]) code = 4'(i);
    return BCD_EN ? code : 4'hF;
  endfunction

  function automatic logic [50:0] outs();
    return {D1, D2, D3, D4, B1, B2, B3, B4, VALID, FRAME, ERR};
  endfunction

  function automatic logic [50:0] model_outs();
    return {m_d[0], m_d[1], m_d[2], m_d[3],
            dec(m_d[0]), dec(m_d[1]), dec(m_d[2]), dec(m_d[3]),
            m_valid, m_frame, m_err};
  endfunction

  task automatic check(input string name, input logic [50:0] act, input logic [50:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
  endtask

  task automatic model_reset();
    m_prev = '0; m_run = 0; m_age = 0;
    got.delete();
    for (int i = 0; i < 4; i++) m_d[i] = 8'hFF;
    m_valid = 1'b0; m_frame = 1'b0; m_err = 1'b0;
  endtask

  // Outcome of the coming clock edge, decided from pins driven before earlier edges.
  task automatic model_edge();
    logic [3:0] sa;
    int k;
    m_frame = 1'b0;
    m_err   = 1'b0;
    if (m_valid) begin
      m_age++;
      if (m_age >= TO) m_valid = 1'b0;
    end
    if (m_run == S) begin
      sa = m_prev[11:8];
      if ($countones(sa) > 1) begin
        m_err = 1'b1;
        got.delete();
      end else if (sa != 4'b0) begin
        k = 0;
        for (int i = 0; i < 4; i++) if (sa[i]) k = i;
        if (got.size() == 0) begin
          if (k == 0) got.push_back(m_prev[7:0]);
        end else if (k == got.size()) begin
          got.push_back(m_prev[7:0]);
          if (got.size() == 4) begin
            for (int i = 0; i < 4; i++) m_d[i] = got[3-i];
            m_frame = 1'b1; m_valid = 1'b1; m_age = 0;
            last_frame_cyc = cyc + 1;
            got.delete();
          end
        end else begin
          m_err = 1'b1;
          got.delete();
          if (k == 0) got.push_back(m_prev[7:0]);
        end
      end
    end
  endtask

  task automatic step(input logic [3:0] sa, input logic [7:0] l);
    model_edge();
    SA = sa;
    L  = l;
    if ({sa, l} == m_prev) begin
      if (m_run < 1000) m_run++;
    end else begin
      m_prev = {sa, l};
      m_run  = 1;
    end
    @(posedge CLK);
    cyc++;
    #1;
    check("outputs", outs(), model_outs());
    if (FRAME) dut_frames++;
    if (ERR)   dut_errs++;
  endtask

  task automatic slot(input logic [3:0] sa, input logic [7:0] l,
                      input int unsigned hold, input int unsigned blank);
    for (int unsigned i = 0; i < hold; i++) step(sa, l);
    for (int unsigned i = 0; i < blank; i++) step(4'b0, 8'hFF);
  endtask

  task automatic scan_frame(input logic [31:0] pins, input int unsigned hold);
    slot(4'b0001, pins[31:24], hold, 1);
    slot(4'b0010, pins[23:16], hold, 1);
    slot(4'b0100, pins[15:8],  hold, 1);
    slot(4'b1000, pins[7:0],   hold, 1);
  endtask

  task automatic check_db(input string name, input int idx);
    check(name, {19'b0, D1, D2, D3, D4, B1, B2, B3, B4},
          {19'b0, vecs[idx].exp_d, BCD_EN ? vecs[idx].exp_b : 16'hFFFF});
  endtask

  task automatic random_phase();
    logic [3:0] sa;
    logic [7:0] l;
    int unsigned r, hold, pos, k;
    bit glitch;
    pos = 0;
    for (int n = 0; n < 250; n++) begin
      r    = $urandom_range(0, 19);
      hold = $urandom_range(1, 4);
      l    = ($urandom_range(0, 3) == 0) ? 8'($urandom)
                                         : {1'($urandom), SEG_TBL[$urandom_range(0, 9)]};
      if (r == 0) sa = 4'b0011 << $urandom_range(0, 2);
      else if (r <= 2) sa = 4'b0001 << $urandom_range(0, 3);
      else if (r == 3) begin
        repeat ($urandom_range(50, 80)) step(4'b0, 8'hFF);
        sa = 4'b0001;
        pos = 0;
      end else sa = 4'b0001 << pos;
      glitch = ($urandom_range(0, 7) == 0);
      for (int unsigned i = 0; i < hold; i++)
        step(sa, (glitch && i == 1) ? (l ^ 8'h5A) : l);
      slot(4'b0, 8'hFF, 0, $urandom_range(0, 2));
      if ($countones(sa) != 1) pos = 0;
      else begin
        k = 0;
        for (int i = 0; i < 4; i++) if (sa[i]) k = i;
        pos = (k == pos) ? (pos + 1) % 4 : ((k == 0) ? 1 : 0);
      end
    end
  endtask

  initial begin
    int unsigned f0, e0, f_at, guard;

    vecs[0] = '{32'hC0F9A4B0, 32'hB0A4F9C0, 16'h3210};
    vecs[1] = '{32'h999282F8, 32'hF8829299, 16'h7654};
    vecs[2] = '{32'h80900010, 32'h10009080, 16'h9898};
    vecs[3] = '{32'hFF7F4140, 32'h40417FFF, 16'h0FFF};
    vecs[4] = '{32'h79243012, 32'h12302479, 16'h5321};

    RST = 1'b1; SA = 4'b0; L = 8'hFF;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    check("reset_values", outs(), RESET_OUTS);
    RST = 1'b0;

    // table of full frames: 4-cycle slots with one blank cycle between
    for (int i = 0; i < 5; i++) begin
      f0 = dut_frames;
      scan_frame(vecs[i].pins, 4);
      check("table_frame_count", 51'(dut_frames - f0), 51'd1);
      check_db("table_digits", i);
      check("table_valid", 51'(VALID), 51'd1);
    end

    // one-cycle spike inside the SA[1] slot must not be captured
    f0 = dut_frames; e0 = dut_errs;
    slot(4'b0001, 8'hC0, 4, 1);
    step(4'b0010, 8'hF9); step(4'b0010, 8'h00); step(4'b0010, 8'hF9); step(4'b0010, 8'hF9);
    step(4'b0, 8'hFF);
    slot(4'b0100, 8'hA4, 4, 1);
    slot(4'b1000, 8'hB0, 4, 1);
    check("glitch_frame", 51'(dut_frames - f0), 51'd1);
    check("glitch_no_err", 51'(dut_errs - e0), 51'd0);
    check_db("glitch_digits", 0);

    // out-of-order SA[2] after SA[0], then clean recovery
    f0 = dut_frames; e0 = dut_errs;
    slot(4'b0001, 8'h99, 3, 1);
    slot(4'b0100, 8'h82, 3, 1);
    check("order_err", 51'(dut_errs - e0), 51'd1);
    check("order_no_frame", 51'(dut_frames - f0), 51'd0);
    check_db("order_digits_kept", 0);
    scan_frame(vecs[1].pins, 3);
    check("order_recovery", 51'(dut_frames - f0), 51'd1);
    check_db("order_recovery_digits", 1);

    // multi-hot stable slot aborts the partial frame back to SYNC
    f0 = dut_frames; e0 = dut_errs;
    slot(4'b0001, 8'hC0, 3, 1);
    slot(4'b0011, 8'hC0, 3, 1);
    slot(4'b0010, 8'hF9, 3, 1);
    slot(4'b0100, 8'hA4, 3, 1);
    slot(4'b1000, 8'hB0, 3, 1);
    check("multihot_err", 51'(dut_errs - e0), 51'd1);
    check("multihot_no_frame", 51'(dut_frames - f0), 51'd0);
    check_db("multihot_digits_kept", 1);

    // asynchronous reset mid-frame; the frame in progress must not complete
    slot(4'b0001, 8'hC0, 4, 1);
    slot(4'b0010, 8'hF9, 4, 1);
    RST = 1'b1;
    #1;
    check("async_reset", outs(), RESET_OUTS);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    model_reset();
    f0 = dut_frames;
    slot(4'b0100, 8'hA4, 4, 1);
    slot(4'b1000, 8'hB0, 4, 1);
    check("reset_no_frame", 51'(dut_frames - f0), 51'd0);
    scan_frame(vecs[0].pins, 4);
    check("reset_then_frame", 51'(dut_frames - f0), 51'd1);

    // VALID falls exactly TO cycles after FRAME
    scan_frame(vecs[2].pins, S);
    f_at = last_frame_cyc;
    guard = 0;
    while (VALID && guard < 200) begin
      step(4'b0, 8'hFF);
      guard++;
    end
    check("timeout_len", 51'(cyc - f_at), 51'(TO));
    check_db("timeout_digits_kept", 2);

    // a frame completing on the expiry edge keeps VALID high
    scan_frame(vecs[1].pins, S);
    f_at = last_frame_cyc;
    slot(4'b0001, 8'h99, S, 1);
    slot(4'b0010, 8'h92, S, 1);
    slot(4'b0100, 8'h82, S, 1);
    while (cyc < f_at + TO - 3) step(4'b0, 8'hFF);
    step(4'b1000, 8'hF8);
    step(4'b1000, 8'hF8);
    step(4'b0, 8'hFF);
    check("frame_at_expiry", 51'({VALID, FRAME}), 51'b11);

    random_phase();
    repeat (80) step(4'b0, 8'hFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
